point_link_arbiter: RTL and testbench

Shares one point-to-point simbus master link among up to NUM_REQ local requesters. Each request is one tagged outbound word. The block then waits for the matching tagged reply and returns it to the issuing requester. A reply timeout guarantees forward progress. The arbiter sits between the DUT-side client logic and the point master I/O module: link_o drives that module's data_o, and link_i is fed from its data_i.

---
 rtl/point_link_arbiter_if.sv | 30 +++
 rtl/point_link_arbiter.sv | 131 +++++++++++++
 tb/tb_point_link_arbiter.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/point_link_arbiter_if.sv
// Signal bundle between local requesters, the arbiter and the point master I/O link.
// The arbiter uses the slave view; client logic and the link side use the master view.
interface point_link_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int TAG_W   = 2,
    parameter int WIDTH_D = 8
);
    localparam int LW = 1 + TAG_W + WIDTH_D;

    logic [NUM_REQ-1:0]         req;
    logic [NUM_REQ*WIDTH_D-1:0] req_data;
    logic [NUM_REQ-1:0]         gnt;
    logic [NUM_REQ-1:0]         rsp_valid;
    logic [WIDTH_D-1:0]         rsp_data;
    logic                       rsp_err;
    logic                       busy;
    logic [7:0]                 stray_cnt;
    logic [LW-1:0]              link_o;
    logic [LW-1:0]              link_i;

    modport slave (
        input  req, req_data, link_i,
        output gnt, rsp_valid, rsp_data, rsp_err, busy, stray_cnt, link_o
    );

    modport master (
        output req, req_data, link_i,
        input  gnt, rsp_valid, rsp_data, rsp_err, busy, stray_cnt, link_o
    );
endinterface

// File: rtl/point_link_arbiter.sv
// Round-robin arbiter sharing one tagged request/reply link among NUM_REQ requesters,
// with a reply timeout and a saturating counter of discarded inbound words.
module point_link_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TAG_W   = 2,
    parameter int WIDTH_D = 8,
    parameter int TIMEOUT = 64
) (
    input  logic                  clock,
    input  logic                  reset_n,
    point_link_arbiter_if.slave   bus
);
    localparam int LW = 1 + TAG_W + WIDTH_D;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic {IDLE, WAIT} state_t;

    state_t               state_reg, state_next;
    logic [TAG_W-1:0]     cur_reg, cur_next;
    logic [TAG_W-1:0]     last_reg, last_next;
    logic [TW-1:0]        timer_reg, timer_next;
    logic [NUM_REQ-1:0]   gnt_reg, gnt_next;
    logic [NUM_REQ-1:0]   rsp_valid_reg, rsp_valid_next;
    logic [WIDTH_D-1:0]   rsp_data_reg, rsp_data_next;
    logic                 rsp_err_reg, rsp_err_next;
    logic [7:0]           stray_reg, stray_next;
    logic [LW-1:0]        link_o_reg, link_o_next;

    logic [TAG_W-1:0]     winner;
    logic                 found;
    logic                 in_valid;
    logic [TAG_W-1:0]     in_tag;
    logic                 match;
    logic                 stray_in;

    assign in_valid = bus.link_i[LW-1];
    assign in_tag   = bus.link_i[LW-2 -: TAG_W];
    // cur always holds a legal index, so out-of-range tags can never match
    assign match    = (state_reg == WAIT) && in_valid && (in_tag == cur_reg);
    assign stray_in = in_valid && !match;

    // First requester above the last winner, wrapping around
    always_comb begin
        winner = last_reg;
        found  = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!found && bus.req[(int'(last_reg) + k) % NUM_REQ]) begin
                winner = TAG_W'((int'(last_reg) + k) % NUM_REQ);
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        state_next     = state_reg;
        cur_next       = cur_reg;
        last_next      = last_reg;
        timer_next     = timer_reg;
        gnt_next       = '0;
        rsp_valid_next = '0;
        rsp_err_next   = 1'b0;
        rsp_data_next  = rsp_data_reg;
        link_o_next    = {1'b0, link_o_reg[LW-2:0]};
        stray_next     = stray_reg;

        if (stray_in && (stray_reg != 8'hFF))
            stray_next = stray_reg + 8'd1;

        case (state_reg)
            IDLE: begin
                if (found) begin
                    gnt_next    = NUM_REQ'(1) << winner;
                    link_o_next = {1'b1, winner, bus.req_data[winner*WIDTH_D +: WIDTH_D]};
                    cur_next    = winner;
                    last_next   = winner;
                    timer_next  = '0;
                    state_next  = WAIT;
                end
            end
            WAIT: begin
                timer_next = timer_reg + TW'(1);
                // A reply landing in the timeout cycle takes precedence
                if (match) begin
                    rsp_valid_next = NUM_REQ'(1) << cur_reg;
                    rsp_data_next  = bus.link_i[WIDTH_D-1:0];
                    state_next     = IDLE;
                end else if ((TIMEOUT != 0) && (timer_reg == TW'(TIMEOUT - 1))) begin
                    rsp_valid_next = NUM_REQ'(1) << cur_reg;
                    rsp_data_next  = '0;
                    rsp_err_next   = 1'b1;
                    state_next     = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= IDLE;
            cur_reg       <= '0;
            last_reg      <= TAG_W'(NUM_REQ - 1);
            timer_reg     <= '0;
            gnt_reg       <= '0;
            rsp_valid_reg <= '0;
            rsp_data_reg  <= '0;
            rsp_err_reg   <= 1'b0;
            stray_reg     <= '0;
            link_o_reg    <= '0;
        end else begin
            state_reg     <= state_next;
            cur_reg       <= cur_next;
            last_reg      <= last_next;
            timer_reg     <= timer_next;
            gnt_reg       <= gnt_next;
            rsp_valid_reg <= rsp_valid_next;
            rsp_data_reg  <= rsp_data_next;
            rsp_err_reg   <= rsp_err_next;
            stray_reg     <= stray_next;
            link_o_reg    <= link_o_next;
        end
    end

    assign bus.gnt       = gnt_reg;
    assign bus.rsp_valid = rsp_valid_reg;
    assign bus.rsp_data  = rsp_data_reg;
    assign bus.rsp_err   = rsp_err_reg;
    assign bus.busy      = (state_reg == WAIT);
    assign bus.stray_cnt = stray_reg;
    assign bus.link_o    = link_o_reg;
endmodule

// File: tb/tb_point_link_arbiter.sv
// Directed bench for point_link_arbiter: grant/reply path, round-robin order,
// timeout, stray counting and saturation, reply/timeout race, reset mid-transaction.
module tb_point_link_arbiter;
    localparam int NUM_REQ = 4;
    localparam int TAG_W   = 2;
    localparam int WIDTH_D = 8;
    localparam int TIMEOUT = 64;
    localparam int LW      = 1 + TAG_W + WIDTH_D;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    int   tests   = 0;
    int   fails   = 0;

    always #5 clock = ~clock;

    point_link_arbiter_if #(.NUM_REQ(NUM_REQ), .TAG_W(TAG_W), .WIDTH_D(WIDTH_D)) bus();

    point_link_arbiter #(
        .NUM_REQ(NUM_REQ), .TAG_W(TAG_W), .WIDTH_D(WIDTH_D), .TIMEOUT(TIMEOUT)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [LW-1:0] word(logic v, logic [TAG_W-1:0] t, logic [WIDTH_D-1:0] d);
        return {v, t, d};
    endfunction

    task automatic do_reset();
        bus.req    = '0;
        bus.link_i = '0;
        reset_n    = 1'b0;
        #3;
        reset_n    = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        bus.req      = '0;
        bus.req_data = '0;
        bus.link_i   = '0;
        reset_n      = 1'b0;
        #3;
        tests++; if (bus.gnt !== 4'b0000) begin fails++; $display("FAIL reset_gnt got=%b exp=0000", bus.gnt); end
        tests++; if (bus.rsp_valid !== 4'b0000) begin fails++; $display("FAIL reset_rsp_valid got=%b exp=0000", bus.rsp_valid); end
        tests++; if (bus.rsp_data !== 8'h00) begin fails++; $display("FAIL reset_rsp_data got=%h exp=00", bus.rsp_data); end
        tests++; if (bus.rsp_err !== 1'b0) begin fails++; $display("FAIL reset_rsp_err got=%b exp=0", bus.rsp_err); end
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        tests++; if (bus.stray_cnt !== 8'd0) begin fails++; $display("FAIL reset_stray got=%0d exp=0", bus.stray_cnt); end
        tests++; if (bus.link_o !== 11'h000) begin fails++; $display("FAIL reset_link_o got=%h exp=000", bus.link_o); end
        reset_n = 1'b1;
        tick();
        $display("[TB] test_reset done");
    endtask

    task automatic test_single();
        bus.req_data = {8'h00, 8'h00, 8'h00, 8'h5A};
        bus.req      = 4'b0001;
        tick();
        tests++; if (bus.gnt !== 4'b0001) begin fails++; $display("FAIL single_gnt got=%b exp=0001", bus.gnt); end
        tests++; if (bus.link_o !== word(1'b1, 2'd0, 8'h5A)) begin fails++; $display("FAIL single_link_o got=%h exp=%h", bus.link_o, word(1'b1, 2'd0, 8'h5A)); end
        tests++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL single_busy got=%b exp=1", bus.busy); end
        bus.req = 4'b0000;
        tick();
        tests++; if (bus.gnt !== 4'b0000) begin fails++; $display("FAIL single_gnt_pulse got=%b exp=0000", bus.gnt); end
        tests++; if (bus.link_o !== word(1'b0, 2'd0, 8'h5A)) begin fails++; $display("FAIL single_link_hold got=%h exp=%h", bus.link_o, word(1'b0, 2'd0, 8'h5A)); end
        bus.link_i = word(1'b1, 2'd0, 8'hA5);
        tick();
        bus.link_i = '0;
        tests++; if (bus.rsp_valid !== 4'b0001) begin fails++; $display("FAIL single_rsp_valid got=%b exp=0001", bus.rsp_valid); end
        tests++; if (bus.rsp_data !== 8'hA5) begin fails++; $display("FAIL single_rsp_data got=%h exp=a5", bus.rsp_data); end
        tests++; if (bus.rsp_err !== 1'b0) begin fails++; $display("FAIL single_rsp_err got=%b exp=0", bus.rsp_err); end
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL single_busy_end got=%b exp=0", bus.busy); end
        tick();
        tests++; if (bus.rsp_valid !== 4'b0000) begin fails++; $display("FAIL single_rsp_pulse got=%b exp=0000", bus.rsp_valid); end
        tests++; if (bus.rsp_data !== 8'hA5) begin fails++; $display("FAIL single_rsp_data_hold got=%h exp=a5", bus.rsp_data); end
        $display("[TB] test_single done");
    endtask

    task automatic test_round_robin();
        logic [NUM_REQ*WIDTH_D-1:0] pay;
        logic [WIDTH_D-1:0]         reply;
        logic [NUM_REQ-1:0]         exp_oh;
        int                         exp;
        do_reset();
        pay          = {8'h44, 8'h33, 8'h22, 8'h11};
        bus.req_data = pay;
        bus.req      = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            exp    = n % NUM_REQ;
            exp_oh = 4'b0001 << exp;
            reply  = 8'hC0 + 8'(n);
            tick();
            tests++; if (bus.gnt !== exp_oh) begin fails++; $display("FAIL rr_gnt n=%0d got=%b exp=%b", n, bus.gnt, exp_oh); end
            tests++; if (bus.link_o !== word(1'b1, 2'(exp), pay[exp*WIDTH_D +: WIDTH_D])) begin fails++; $display("FAIL rr_link_o n=%0d got=%h exp=%h", n, bus.link_o, word(1'b1, 2'(exp), pay[exp*WIDTH_D +: WIDTH_D])); end
            bus.link_i = word(1'b1, 2'(exp), reply);
            tick();
            bus.link_i = '0;
            tests++; if (bus.rsp_valid !== exp_oh) begin fails++; $display("FAIL rr_rsp_valid n=%0d got=%b exp=%b", n, bus.rsp_valid, exp_oh); end
            tests++; if (bus.rsp_data !== reply) begin fails++; $display("FAIL rr_rsp_data n=%0d got=%h exp=%h", n, bus.rsp_data, reply); end
            $display("[TB] rr txn %0d: grant to %0d", n, exp);
        end
        bus.req = 4'b0000;
        tick();
    endtask

    task automatic test_timeout();
        bus.req_data = {8'h00, 8'h99, 8'h00, 8'h00};
        bus.req      = 4'b0100;
        tick();
        tests++; if (bus.gnt !== 4'b0100) begin fails++; $display("FAIL to_gnt got=%b exp=0100", bus.gnt); end
        bus.req = 4'b0000;
        repeat (63) tick();
        tests++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL to_busy_before got=%b exp=1", bus.busy); end
        tests++; if (bus.rsp_valid !== 4'b0000) begin fails++; $display("FAIL to_early got=%b exp=0000", bus.rsp_valid); end
        tick();
        tests++; if (bus.rsp_valid !== 4'b0100) begin fails++; $display("FAIL to_rsp_valid got=%b exp=0100", bus.rsp_valid); end
        tests++; if (bus.rsp_err !== 1'b1) begin fails++; $display("FAIL to_rsp_err got=%b exp=1", bus.rsp_err); end
        tests++; if (bus.rsp_data !== 8'h00) begin fails++; $display("FAIL to_rsp_data got=%h exp=00", bus.rsp_data); end
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL to_busy_after got=%b exp=0", bus.busy); end
        tick();
        tests++; if (bus.rsp_err !== 1'b0) begin fails++; $display("FAIL to_err_pulse got=%b exp=0", bus.rsp_err); end
        $display("[TB] test_timeout done");
    endtask

    task automatic test_stray();
        do_reset();
        bus.req_data = {8'h00, 8'h21, 8'h00, 8'h00};
        bus.req      = 4'b0100;
        tick();
        tests++; if (bus.gnt !== 4'b0100) begin fails++; $display("FAIL stray_gnt got=%b exp=0100", bus.gnt); end
        bus.req    = 4'b0000;
        bus.link_i = word(1'b1, 2'd1, 8'h11);
        tick();
        tests++; if (bus.stray_cnt !== 8'd1) begin fails++; $display("FAIL stray_wrong_tag got=%0d exp=1", bus.stray_cnt); end
        tests++; if (bus.rsp_valid !== 4'b0000) begin fails++; $display("FAIL stray_no_rsp got=%b exp=0000", bus.rsp_valid); end
        bus.link_i = word(1'b0, 2'd2, 8'h55);
        tick();
        tests++; if (bus.rsp_valid !== 4'b0000) begin fails++; $display("FAIL stray_invalid_word got=%b exp=0000", bus.rsp_valid); end
        bus.link_i = word(1'b1, 2'd2, 8'h33);
        tick();
        tests++; if (bus.rsp_valid !== 4'b0100) begin fails++; $display("FAIL stray_rsp_valid got=%b exp=0100", bus.rsp_valid); end
        tests++; if (bus.rsp_data !== 8'h33) begin fails++; $display("FAIL stray_rsp_data got=%h exp=33", bus.rsp_data); end
        tests++; if (bus.stray_cnt !== 8'd1) begin fails++; $display("FAIL stray_after_match got=%0d exp=1", bus.stray_cnt); end
        bus.link_i = word(1'b1, 2'd3, 8'h77);
        repeat (10) tick();
        tests++; if (bus.stray_cnt !== 8'd11) begin fails++; $display("FAIL stray_idle_count got=%0d exp=11", bus.stray_cnt); end
        repeat (290) tick();
        bus.link_i = '0;
        tests++; if (bus.stray_cnt !== 8'd255) begin fails++; $display("FAIL stray_saturate got=%0d exp=255", bus.stray_cnt); end
        $display("[TB] test_stray done");
    endtask

    task automatic test_timeout_race();
        bus.req_data = {8'h00, 8'h00, 8'h12, 8'h00};
        bus.req      = 4'b0010;
        tick();
        tests++; if (bus.gnt !== 4'b0010) begin fails++; $display("FAIL race_gnt got=%b exp=0010", bus.gnt); end
        bus.req = 4'b0000;
        repeat (63) tick();
        bus.link_i = word(1'b1, 2'd1, 8'h6C);
        tick();
        bus.link_i = '0;
        tests++; if (bus.rsp_valid !== 4'b0010) begin fails++; $display("FAIL race_rsp_valid got=%b exp=0010", bus.rsp_valid); end
        tests++; if (bus.rsp_err !== 1'b0) begin fails++; $display("FAIL race_rsp_err got=%b exp=0", bus.rsp_err); end
        tests++; if (bus.rsp_data !== 8'h6C) begin fails++; $display("FAIL race_rsp_data got=%h exp=6c", bus.rsp_data); end
        tests++; if (bus.stray_cnt !== 8'd255) begin fails++; $display("FAIL race_stray got=%0d exp=255", bus.stray_cnt); end
        tick();
        $display("[TB] test_timeout_race done");
    endtask

    task automatic test_reset_mid();
        bus.req_data = {8'h3E, 8'h00, 8'h00, 8'h00};
        bus.req      = 4'b1000;
        tick();
        tests++; if (bus.gnt !== 4'b1000) begin fails++; $display("FAIL rmid_gnt got=%b exp=1000", bus.gnt); end
        bus.req = 4'b0000;
        repeat (2) tick();
        reset_n = 1'b0;
        #2;
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL rmid_busy got=%b exp=0", bus.busy); end
        tests++; if (bus.stray_cnt !== 8'd0) begin fails++; $display("FAIL rmid_stray_clr got=%0d exp=0", bus.stray_cnt); end
        reset_n = 1'b1;
        tick();
        bus.link_i = word(1'b1, 2'd3, 8'h5E);
        tick();
        bus.link_i = '0;
        tests++; if (bus.rsp_valid !== 4'b0000) begin fails++; $display("FAIL rmid_no_rsp got=%b exp=0000", bus.rsp_valid); end
        tests++; if (bus.stray_cnt !== 8'd1) begin fails++; $display("FAIL rmid_stray got=%0d exp=1", bus.stray_cnt); end
        bus.req = 4'b1111;
        tick();
        bus.req = 4'b0000;
        tests++; if (bus.gnt !== 4'b0001) begin fails++; $display("FAIL rmid_next_gnt got=%b exp=0001", bus.gnt); end
        $display("[TB] test_reset_mid done");
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_timeout();
        test_stray();
        test_timeout_race();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end
endmodule
